// File: rtl/camera_pkg.sv
// Shared types and constants for the camera frame controller.
package camera_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXPOSE  = 2'd1,
    READOUT = 2'd2
  } state_t;

  // Default exposure clamp limits, in ms.
  localparam int EXP_MIN_DEFAULT = 2;
  localparam int EXP_MAX_DEFAULT = 30;

  // Readout step landmarks. Steps 0..2 read row 1, steps 4..6 read row 2,
  // and steps 3 and 7 are idle gaps between rows.
  localparam logic [2:0] ROW1_ADC   = 3'd1;
  localparam logic [2:0] ROW2_START = 3'd4;
  localparam logic [2:0] ROW2_ADC   = 3'd5;
  localparam logic [2:0] LAST_STEP  = 3'd7;

  typedef struct packed {
    logic nre_1;
    logic nre_2;
    logic adc;
  } readout_t;

  // Sensor/ADC pin values for a given readout step.
  function automatic readout_t readout_decode(input logic [2:0] step);
    readout_t r;
    r.nre_1 = 1'b1;
    r.nre_2 = 1'b1;
    r.adc   = (step == ROW1_ADC) || (step == ROW2_ADC);
    if (step < (ROW2_START - 3'd1)) begin
      r.nre_1 = 1'b0;
    end else if ((step >= ROW2_START) && (step < LAST_STEP)) begin
      r.nre_2 = 1'b0;
    end
    return r;
  endfunction

  // Clamp the requested exposure time into [lo, hi].
  function automatic logic [4:0] clamp_exp(input logic [4:0] t, input int lo, input int hi);
    if (int'(t) < lo) return 5'(lo);
    if (int'(t) > hi) return 5'(hi);
    return t;
  endfunction

endpackage

// File: rtl/exposure_timer.sv
// Millisecond exposure timer: a prescaler divides Clk down to 1 ms ticks and
// ms_cnt counts those ticks. done marks the last Clk cycle of the exposure.
module exposure_timer #(
  parameter int CLK_PER_MS = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [4:0] target,
  output logic       done
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] presc;
  logic [4:0]    ms_cnt;
  logic          wrap;

  assign wrap = (presc == PRESC_LAST);
  assign done = enable && wrap && (ms_cnt == (target - 5'd1));

  // Prescaler and millisecond counter; clear has priority over counting.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (clear) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (enable) begin
      if (wrap) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 5'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/exposure_sequencer.sv
// Frame controller: one frame per Init rising edge, consisting of pixel erase
// (idle), exposure for the clamped time, then an 8-step two-row readout.
//
// Readout handshake: the sensor is read by strobes, not by valid/ready. NRE_x
// low means "row x is driving the column lines"; ADC high for one cycle means
// "sample now" and is only ever issued in the middle cycle of an NRE_x low
// window, so the data is stable a full cycle either side of the sample.
module exposure_sequencer
  import camera_pkg::*;
#(
  parameter int CLK_PER_MS = 1000,
  parameter int EXP_MIN    = EXP_MIN_DEFAULT,
  parameter int EXP_MAX    = EXP_MAX_DEFAULT
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Init,
  input  logic [4:0] Exp_Time,
  output logic       Erase,
  output logic       Expose,
  output logic       NRE_1,
  output logic       NRE_2,
  output logic       ADC,
  output logic       Busy,
  output logic       Frame_Done
);

  state_t     state, state_n;
  logic [2:0] step, step_n;
  logic [4:0] exp_lat, exp_lat_n;
  logic       init_q;
  logic       start;
  logic       timer_done;
  readout_t   ro_n;

  logic erase_n, expose_n, nre_1_n, nre_2_n, adc_n, busy_n, frame_done_n;

  assign start = Init & ~init_q;

  exposure_timer #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (state == IDLE),
    .enable(state == EXPOSE),
    .target(exp_lat),
    .done  (timer_done)
  );

  // Next state and next output values; outputs are registered so each state's
  // pin values appear on the same edge that enters it.
  always_comb begin
    state_n      = state;
    step_n       = step;
    exp_lat_n    = exp_lat;
    erase_n      = 1'b1;
    expose_n     = 1'b0;
    nre_1_n      = 1'b1;
    nre_2_n      = 1'b1;
    adc_n        = 1'b0;
    busy_n       = 1'b0;
    frame_done_n = 1'b0;
    ro_n         = readout_decode(step + 3'd1);
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = EXPOSE;
          exp_lat_n = clamp_exp(Exp_Time, EXP_MIN, EXP_MAX);
          step_n    = 3'd0;
          erase_n   = 1'b0;
          expose_n  = 1'b1;
          busy_n    = 1'b1;
        end
      end
      EXPOSE: begin
        erase_n  = 1'b0;
        busy_n   = 1'b1;
        expose_n = 1'b1;
        if (timer_done) begin
          state_n  = READOUT;
          step_n   = 3'd0;
          expose_n = 1'b0;
          ro_n     = readout_decode(3'd0);
          nre_1_n  = ro_n.nre_1;
          nre_2_n  = ro_n.nre_2;
          adc_n    = ro_n.adc;
        end
      end
      READOUT: begin
        erase_n = 1'b0;
        busy_n  = 1'b1;
        if (step == LAST_STEP) begin
          state_n      = IDLE;
          frame_done_n = 1'b1;
          erase_n      = 1'b1;
          busy_n       = 1'b0;
        end else begin
          step_n  = step + 3'd1;
          nre_1_n = ro_n.nre_1;
          nre_2_n = ro_n.nre_2;
          adc_n   = ro_n.adc;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, latched exposure, trigger history and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      step       <= '0;
      exp_lat    <= '0;
      init_q     <= 1'b0;
      Erase      <= 1'b1;
      Expose     <= 1'b0;
      NRE_1      <= 1'b1;
      NRE_2      <= 1'b1;
      ADC        <= 1'b0;
      Busy       <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      exp_lat    <= exp_lat_n;
      init_q     <= Init;
      Erase      <= erase_n;
      Expose     <= expose_n;
      NRE_1      <= nre_1_n;
      NRE_2      <= nre_2_n;
      ADC        <= adc_n;
      Busy       <= busy_n;
      Frame_Done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed bench for exposure_sequencer with CLK_PER_MS = 4.
module tb_exposure_sequencer;

  localparam int CPM = 4;

  // Clock / reset
  logic       Clk = 1'b0;
  logic       Reset;
  logic       Init;
  logic [4:0] Exp_Time;
  logic       Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_Done;

  always #5 Clk = ~Clk;

  exposure_sequencer #(
    .CLK_PER_MS(CPM)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Init      (Init),
    .Exp_Time  (Exp_Time),
    .Erase     (Erase),
    .Expose    (Expose),
    .NRE_1     (NRE_1),
    .NRE_2     (NRE_2),
    .ADC       (ADC),
    .Busy      (Busy),
    .Frame_Done(Frame_Done)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] et;
    int         exp_len;
  } vec_t;

  vec_t       vecs[7];
  logic [2:0] ro_exp[8];  // {NRE_1, NRE_2, ADC} per readout step

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pin invariants held at every sampled cycle outside reset.
  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      checks++;
      if ((NRE_1 === 1'b0 && NRE_2 === 1'b0) || (Expose === 1'b1 && Erase === 1'b1)) begin
        errors++;
        $display("FAIL invariant: NRE_1=%b NRE_2=%b Expose=%b Erase=%b", NRE_1, NRE_2, Expose, Erase);
      end
    end
  end

  // Driver: raise Init at a negedge; optionally keep it high.
  task automatic start(input logic [4:0] et, input bit hold);
    Exp_Time = et;
    Init = 1'b1;
    @(negedge Clk);
    if (!hold) Init = 1'b0;
  endtask

  // Count Expose-high cycles; optionally glitch Init or change Exp_Time mid-way.
  task automatic measure_expose(input int exp_len, input string nm, input int glitch_at, input int change_at);
    int n;
    int bad;
    n = 0;
    bad = 0;
    while (Expose === 1'b1 && n < 200) begin
      if (Busy !== 1'b1 || Erase !== 1'b0) bad++;
      n++;
      if (n == glitch_at) Init = 1'b1;
      else if (n == glitch_at + 1) Init = 1'b0;
      if (n == change_at) Exp_Time = 5'd3;
      @(negedge Clk);
    end
    check({nm, " expose_len"}, n, exp_len);
    check({nm, " busy_during_expose"}, bad, 0);
  endtask

  task automatic check_readout(input string nm);
    for (int s = 0; s < 8; s++) begin
      check($sformatf("%s ro_step%0d", nm, s),
            {NRE_1, NRE_2, ADC, Busy, Expose, Erase}, {ro_exp[s], 3'b100});
      @(negedge Clk);
    end
  endtask

  task automatic check_done(input string nm, input bit b2b);
    check({nm, " done_cycle"}, {Frame_Done, Busy, Erase, Expose}, 4'b1010);
    if (b2b) begin
      Init = 1'b1;
      @(negedge Clk);
      Init = 1'b0;
    end else begin
      @(negedge Clk);
      check({nm, " after_done"}, {Frame_Done, Erase, Busy}, 3'b010);
    end
  endtask

  initial begin
    int cnt;

    vecs[0] = '{5'd5, 20};
    vecs[1] = '{5'd0, 8};
    vecs[2] = '{5'd31, 120};
    vecs[3] = '{5'd1, 8};
    vecs[4] = '{5'd2, 8};
    vecs[5] = '{5'd30, 120};
    vecs[6] = '{5'd17, 68};
    ro_exp[0] = 3'b010;
    ro_exp[1] = 3'b011;
    ro_exp[2] = 3'b010;
    ro_exp[3] = 3'b110;
    ro_exp[4] = 3'b100;
    ro_exp[5] = 3'b101;
    ro_exp[6] = 3'b100;
    ro_exp[7] = 3'b110;

    // Reset and idle
    Reset = 1'b1;
    Init = 1'b0;
    Exp_Time = 5'd0;
    #1;
    check("reset_values", {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_Done}, 7'b1011000);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check($sformatf("idle%0d", i), {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_Done}, 7'b1011000);
    end

    // Table: exposure lengths including both clamp limits
    for (int i = 0; i < 7; i++) begin
      string nm;
      nm = $sformatf("vec%0d_et%0d", i, vecs[i].et);
      start(vecs[i].et, 1'b0);
      measure_expose(vecs[i].exp_len, nm, -1, -1);
      check_readout(nm);
      check_done(nm, 1'b0);
      repeat (2) @(negedge Clk);
    end

    // Init held for whole frame, Exp_Time changed mid-exposure
    start(5'd10, 1'b1);
    measure_expose(40, "hold", -1, 10);
    check_readout("hold");
    check_done("hold", 1'b0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (Busy !== 1'b0 || Expose !== 1'b0) cnt++;
      @(negedge Clk);
    end
    check("hold no_retrigger", cnt, 0);
    Init = 1'b0;
    @(negedge Clk);
    start(5'd4, 1'b0);
    measure_expose(16, "rearm", -1, -1);
    check_readout("rearm");
    check_done("rearm", 1'b0);

    // Init edge during EXPOSE ignored; edge in Frame_Done cycle starts next frame
    start(5'd5, 1'b0);
    measure_expose(20, "glitch", 6, -1);
    check_readout("glitch");
    check_done("glitch", 1'b1);
    measure_expose(20, "b2b", -1, -1);
    check_readout("b2b");
    check_done("b2b", 1'b0);

    // Asynchronous reset during readout step 5
    start(5'd2, 1'b0);
    measure_expose(8, "abort", -1, -1);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("abort ro_step%0d", s), {NRE_1, NRE_2, ADC}, ro_exp[s]);
      @(negedge Clk);
    end
    check("abort at_step5", {NRE_1, NRE_2, ADC}, ro_exp[5]);
    #2 Reset = 1'b1;
    #1;
    check("abort async_reset", {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Frame_Done}, 7'b1011000);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (Frame_Done !== 1'b0 || Busy !== 1'b0) cnt++;
      @(negedge Clk);
    end
    check("abort no_frame_done", cnt, 0);
    start(5'd3, 1'b0);
    measure_expose(12, "post_reset", -1, -1);
    check_readout("post_reset");
    check_done("post_reset", 1'b0);

    // Report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exposure_sequencer.md
Name: exposure_sequencer

Overview:
- Top-level frame controller for the digital camera.
- Takes the exposure time from the exposure-time control block (5-bit value, in ms) and sequences one frame per trigger: pixel erase, exposure, then a two-row readout handshake towards the sensor and ADC.
- Exports Busy so the exposure-time controls can be gated while a frame is in progress.

Parameters:
- CLK_PER_MS, 1000: Clk cycles per millisecond. The bench uses 4.
- EXP_MIN, 2: lower clamp for the exposure time, in ms.
- EXP_MAX, 30: upper clamp for the exposure time, in ms.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high; forces all state and outputs to their reset values.
- Init  in  1  frame trigger (button, already synchronised); rising-edge detected internally.
- Exp_Time  in  5  requested exposure time in ms, unsigned.
- Erase  out  1  pixel erase; high while idle.
- Expose  out  1  pixel integrate enable.
- NRE_1  out  1  row-1 read enable, active-low.
- NRE_2  out  1  row-2 read enable, active-low.
- ADC  out  1  ADC sample strobe, one cycle wide.
- Busy  out  1  high from frame start until return to IDLE.
- Frame_Done  out  1  one-cycle pulse at end of frame.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, Erase=1, Expose=0, NRE_1=1, NRE_2=1, ADC=0, Busy=0, Frame_Done=0, init_q=0, counters=0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. Outputs return to the reset values; no Frame_Done is issued.
- Trigger: start = Init & ~init_q, with init_q = Init registered.
  - Holding Init high gives exactly one frame.
  - A new frame needs Init low for at least one sampled cycle.
  - Edges arriving while Busy=1 are ignored and not queued.
- Clamp: exp_lat = max(EXP_MIN, min(EXP_MAX, Exp_Time)).
  - Exp_Time is sampled only on the start cycle.
  - Changes to Exp_Time during a frame have no effect on that frame.
- IDLE:
  - Outputs: Erase=1, Expose=0, Busy=0.
  - On start: latch exp_lat and clear the counters. Next state is EXPOSE, with Erase=0, Expose=1, Busy=1 valid from the same edge.
- EXPOSE:
  - A prescaler counts 0..CLK_PER_MS-1. On wrap, ms_cnt increments.
  - When ms_cnt reaches exp_lat-1 and the prescaler wraps, the next state is READOUT, with Expose=0 and step=0.
  - Expose is high for exactly exp_lat*CLK_PER_MS cycles.
- READOUT: step counter 0..7, one cycle per step; output values during each step:
  - step 0: NRE_1=0.
  - step 1: NRE_1=0, ADC=1.
  - step 2: NRE_1=0.
  - step 3: all inactive.
  - step 4: NRE_2=0.
  - step 5: NRE_2=0, ADC=1.
  - step 6: NRE_2=0.
  - step 7: all inactive. On leaving step 7 the next state is IDLE; Frame_Done=1 for that one cycle, and Erase=1, Busy=0 from the same edge.
- NRE_1 and NRE_2 are never low simultaneously. Expose and Erase are never high simultaneously.
- Total frame length is exp_lat*CLK_PER_MS + 8 cycles, measured from the first Expose=1 cycle to the Frame_Done cycle exclusive.
- Back-to-back frames: a start edge in the Frame_Done cycle is accepted, because the state is IDLE then.
- Counter widths:
  - prescaler: clog2(CLK_PER_MS) bits.
  - ms_cnt: 5 bits.
  - step: 3 bits.
- Unreachable state encodings recover to IDLE on the next edge.

Decomposition:
- Package camera_pkg holds:
  - the state enum (IDLE, EXPOSE, READOUT);
  - EXP_MIN and EXP_MAX defaults;
  - readout step constants (ROW1_ADC=1, ROW2_START=4, ROW2_ADC=5, LAST_STEP=7).
- Sub-module exposure_timer holds the prescaler and ms_cnt.
  - Inputs: clear, enable, target.
  - Output: done, a one-cycle pulse on the final cycle.
- The FSM and output registers stay in exposure_sequencer.

Test Plan (CLK_PER_MS=4):
- Reset, then idle for 10 cycles: Erase=1, NRE_1=NRE_2=1, ADC=0, Busy=0 throughout.
- Exp_Time=5, pulse Init for 1 cycle: Expose high for exactly 20 cycles. Then an 8-cycle readout with ADC pulses at readout cycles 1 and 5, NRE_1 low in cycles 0-2 and NRE_2 low in cycles 4-6. Then one Frame_Done pulse and Erase back to 1.
- Clamp, Exp_Time=0: Expose lasts 8 cycles. Exp_Time=31: Expose lasts 120 cycles.
- Exp_Time=10 at start, changed to 3 mid-exposure, Init held high for the whole frame: Expose lasts 40 cycles, only one frame runs, and no second frame starts until Init drops and rises again.
- A second Init edge during EXPOSE is ignored (Busy stays 1, frame length unchanged). An Init edge in the Frame_Done cycle starts the next frame immediately.
- Reset asserted during readout step 5: all outputs take reset values without waiting for a clock edge, and no Frame_Done pulse follows. After Reset is released, a fresh Init starts a complete frame.
